// File: rtl/sram_bank_ctrl.sv
// Bus-to-SRAM bank controller with retention handshake (ACTIVE/DRAIN/RETENTIVE/WAKEUP).
// Define SRAM_BANK_CTRL_RDATA_REG_EN to add an output register on rvalid_o/rdata_o (latency 2).
module sram_bank_ctrl #(
  parameter int NumWords     = 2048,
  parameter int AddrWidth    = (NumWords <= 1) ? 1 : $clog2(NumWords),
  parameter int WakeupCycles = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  input  logic                 ret_req_i,
  output logic                 ret_ack_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  output logic                 mem_set_retentive_no,
  input  logic [31:0]          mem_rdata_i
);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    RETENTIVE,
    WAKEUP
  } state_e;

  localparam int CntWidth = (WakeupCycles <= 1) ? 1 : $clog2(WakeupCycles);
  localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeupCycles - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] wake_cnt_q, wake_cnt_d;
  logic                retentive_q;
  logic                resp_valid_q, resp_read_q;
  logic                pending;

  assign gnt_o       = req_i && (state_q == ACTIVE) && !ret_req_i;
  assign mem_req_o   = req_i && gnt_o;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = addr_i;
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  assign ret_ack_o            = retentive_q;
  assign mem_set_retentive_no = !retentive_q;

  // First response stage: one entry per grant, remembering whether data must be returned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_read_q  <= 1'b0;
    end else begin
      resp_valid_q <= gnt_o;
      resp_read_q  <= gnt_o && !we_i;
    end
  end

`ifdef SRAM_BANK_CTRL_RDATA_REG_EN
  logic        rvalid_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp_valid_q;
      rdata_q  <= (resp_valid_q && resp_read_q) ? mem_rdata_i : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign pending  = resp_valid_q || rvalid_q;
`else
  assign rvalid_o = resp_valid_q;
  assign rdata_o  = (resp_valid_q && resp_read_q) ? mem_rdata_i : '0;
  assign pending  = resp_valid_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACTIVE;
      wake_cnt_q  <= '0;
      retentive_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      retentive_q <= (state_d == RETENTIVE);
    end
  end

  // A dropped retention request wins over completing the drain.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (ret_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!ret_req_i)    state_d = ACTIVE;
        else if (!pending) state_d = RETENTIVE;
      end
      RETENTIVE: begin
        if (!ret_req_i) begin
          state_d    = WAKEUP;
          wake_cnt_d = '0;
        end
      end
      WAKEUP: begin
        if (wake_cnt_q == WakeLast) begin
          state_d    = ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ACTIVE;
        wake_cnt_d = '0;
      end
    endcase
  end

endmodule
